// File: rtl/rf_write_arbiter_if.sv
// Bundle of register-file write sources and the arbiter's grant/strobe outputs.
// The arbiter side uses the slave modport; producers/regfile use master.
interface rf_write_arbiter_if;
   logic       cpu_we_0;
   logic [4:0] cpu_addr_0;
   logic       cpu_we_1;
   logic [4:0] cpu_addr_1;
   logic       vpu_req;
   logic       vpu_gnt;
   logic       we_VPU;
   logic       key_valid;
   logic [3:0] key_data;
   logic       key_drop;
   logic       SPART_we;
   logic [3:0] SPART_keys;
   logic       hold_pipe;

   modport slave (
      input  cpu_we_0, cpu_addr_0, cpu_we_1, cpu_addr_1,
      input  vpu_req, key_valid, key_data,
      output vpu_gnt, we_VPU, key_drop, SPART_we, SPART_keys, hold_pipe
   );

   modport master (
      output cpu_we_0, cpu_addr_0, cpu_we_1, cpu_addr_1,
      output vpu_req, key_valid, key_data,
      input  vpu_gnt, we_VPU, key_drop, SPART_we, SPART_keys, hold_pipe
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: CPU writeback wins, VPU commit waits out collisions,
// SPART key events are buffered. Define ARB_STATS_EN to add stat_hold/stat_drops.
module rf_write_arbiter #(
   parameter int VREG_BASE = 17,
   parameter int RO_ADDR   = 25,
   parameter int MAX_WAIT  = 4,
   parameter int KEY_DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   rf_write_arbiter_if.slave bus
`ifdef ARB_STATS_EN
   ,
   output logic [15:0] stat_hold,
   output logic [7:0]  stat_drops
`endif
);
   localparam int IDX_W = $clog2(KEY_DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_wait_cnt;
   logic [CNT_W-1:0] w_wait_cnt_next;
   logic             w_grant;

   function automatic logic addr_hit(input logic [4:0] a);
      int v;
      v = int'({27'd0, a});
      return ((v >= VREG_BASE) && (v <= VREG_BASE + 7)) || (v == RO_ADDR);
   endfunction

   logic [1:0] w_cpu_we;
   logic [4:0] w_cpu_addr [2];
   logic [1:0] w_hit;
   logic       w_conflict;

   assign w_cpu_we      = {bus.cpu_we_1, bus.cpu_we_0};
   assign w_cpu_addr[0] = bus.cpu_addr_0;
   assign w_cpu_addr[1] = bus.cpu_addr_1;

   for (genvar gi = 0; gi < 2; gi++) begin : g_hit
      assign w_hit[gi] = w_cpu_we[gi] & addr_hit(w_cpu_addr[gi]);
   end
   assign w_conflict = |w_hit;

   // Grant is Mealy on the current conflict so a VPU commit never lands on a CPU write.
   always_comb begin
      w_state_next    = r_state;
      w_wait_cnt_next = r_wait_cnt;
      w_grant         = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.vpu_req) begin
               w_state_next    = S_WAIT;
               w_wait_cnt_next = '0;
            end
         end
         S_WAIT: begin
            if (!bus.vpu_req) begin
               w_state_next = S_IDLE;
            end else if (!w_conflict) begin
               w_grant      = 1'b1;
               w_state_next = S_IDLE;
            end else begin
               w_wait_cnt_next = r_wait_cnt + 1'b1;
               if (int'(r_wait_cnt) + 1 >= MAX_WAIT - 1) begin
                  w_state_next = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (!bus.vpu_req) begin
               w_state_next = S_IDLE;
            end else if (!w_conflict) begin
               w_grant      = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_wait_cnt <= w_wait_cnt_next;
      end
   end

   logic [3:0]       r_mem [KEY_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                    (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
   // VPU commit takes the write slot on a tie; the key waits a cycle.
   assign w_pop   = !w_empty && !w_grant;
   assign w_push  = bus.key_valid && (!w_full || w_pop);
   assign w_drop  = bus.key_valid && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[IDX_W-1:0]] <= bus.key_data;
   end

   assign bus.we_VPU     = w_grant;
   assign bus.vpu_gnt    = w_grant;
   assign bus.SPART_we   = w_pop;
   assign bus.SPART_keys = w_empty ? 4'd0 : r_mem[r_rd_ptr[IDX_W-1:0]];
   assign bus.key_drop   = w_drop;
   assign bus.hold_pipe  = (r_state == S_HOLD);

`ifdef ARB_STATS_EN
   logic [15:0] r_stat_hold;
   logic [7:0]  r_stat_drops;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_hold  <= '0;
         r_stat_drops <= '0;
      end else begin
         if ((r_state == S_HOLD) && (r_stat_hold != 16'hFFFF)) r_stat_hold <= r_stat_hold + 16'd1;
         if (w_drop && (r_stat_drops != 8'hFF)) r_stat_drops <= r_stat_drops + 8'd1;
      end
   end

   assign stat_hold  = r_stat_hold;
   assign stat_drops = r_stat_drops;
`endif
endmodule
